disp_colour_adapt: RTL and testbench

DISP_COLOUR_ADAPT -- requirements
Module: disp_colour_adapt

---
 rtl/disp_colour_adapt_pkg.sv | 25 ++
 rtl/colour_chan_conv.sv | 80 ++++++++
 rtl/disp_colour_adapt.sv | 118 +++++++++++
 tb/tb_disp_colour_adapt.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/disp_colour_adapt_pkg.sv
// Shared constants and types for the display colour-depth adapter.
package disp_colour_adapt_pkg;

    localparam int unsigned MODE_REPL   = 0;
    localparam int unsigned MODE_ZERO   = 1;
    localparam int unsigned MODE_DITHER = 2;

    localparam int unsigned BPC_MIN = 1;
    localparam int unsigned BPC_MAX = 12;

    // 2x2 Bayer pattern indexed by {y, x}: (0,0)=0, (0,1)=2, (1,0)=3, (1,1)=1
    localparam logic [3:0][1:0] BAYER_2X2 = {2'd1, 2'd3, 2'd2, 2'd0};

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
    } disp_timing_t;

    function automatic logic [1:0] bayer_index(input logic yp, input logic xp,
                                               input logic [1:0] fc);
        return BAYER_2X2[{yp, xp}] + fc;
    endfunction

endpackage

// File: rtl/colour_chan_conv.sv
// One colour channel: stage 1 registers the pixel, stage 2 registers the converted value.
module colour_chan_conv
    import disp_colour_adapt_pkg::*;
#(
    parameter int unsigned BPC_IN  = 5,
    parameter int unsigned BPC_OUT = 8,
    parameter int unsigned MODE    = MODE_REPL
) (
    input  logic               clk_pix,
    input  logic               rst_pix,
    input  logic               de,
    input  logic [1:0]         bayer_idx,
    input  logic [BPC_IN-1:0]  pix_in,
    output logic [BPC_OUT-1:0] pix_out
);

    logic [BPC_IN-1:0]  pix_q;
    logic               de_q;
    logic [1:0]         idx_q;
    logic [BPC_OUT-1:0] conv;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            pix_q <= '0;
            de_q  <= 1'b0;
            idx_q <= 2'd0;
        end else begin
            pix_q <= pix_in;
            de_q  <= de;
            idx_q <= bayer_idx;
        end
    end

    generate
        if (BPC_OUT == BPC_IN) begin : g_pass
            assign conv = pix_q;
        end else if (BPC_OUT > BPC_IN) begin : g_expand
            if (MODE == MODE_ZERO) begin : g_zero
                assign conv = {pix_q, {(BPC_OUT - BPC_IN){1'b0}}};
            end else begin : g_repl
                localparam int unsigned REPS = (BPC_OUT + BPC_IN - 1) / BPC_IN;
                logic [REPS*BPC_IN-1:0] rep;
                logic                   unused_rep;
                assign rep        = {REPS{pix_q}};
                assign conv       = rep[REPS*BPC_IN-1 -: BPC_OUT];
                assign unused_rep = ^rep;
            end
        end else begin : g_reduce
            localparam int unsigned D = BPC_IN - BPC_OUT;
            if (MODE == MODE_DITHER) begin : g_dither
                logic [BPC_IN-1:0] off;
                logic [BPC_IN:0]   sum;
                logic              unused_sum;
                if (D >= 2) begin : g_off_wide
                    assign off = de_q ? (BPC_IN'(idx_q) << (D - 2)) : '0;
                end else begin : g_off_bit
                    assign off = de_q ? BPC_IN'(idx_q[1]) : '0;
                end
                assign sum = {1'b0, pix_q} + {1'b0, off};
                // Carry out of the shifted sum means the result would wrap: saturate instead
                assign conv       = sum[BPC_IN] ? '1 : sum[BPC_IN-1:D];
                assign unused_sum = ^sum[D-1:0];
            end else begin : g_trunc
                assign conv = pix_q[BPC_IN-1 -: BPC_OUT];
            end
        end
    endgenerate

    logic unused_stage1;
    assign unused_stage1 = ^{de_q, idx_q, pix_q};

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            pix_out <= '0;
        end else begin
            pix_out <= conv;
        end
    end

endmodule

// File: rtl/disp_colour_adapt.sv
// Display colour-depth adapter: per-channel conversion with optional 2x2 ordered dither,
// two-cycle latency with timing signals delayed to match.
module disp_colour_adapt
    import disp_colour_adapt_pkg::*;
#(
    parameter int unsigned BPC_IN  = 5,
    parameter int unsigned BPC_OUT = 8,
    parameter int unsigned MODE    = MODE_REPL
) (
    input  logic               clk_pix,
    input  logic               rst_pix,
    input  logic               disp_hsync,
    input  logic               disp_vsync,
    input  logic               disp_de,
    input  logic               disp_frame,
    input  logic [BPC_IN-1:0]  disp_r,
    input  logic [BPC_IN-1:0]  disp_g,
    input  logic [BPC_IN-1:0]  disp_b,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic               out_de,
    output logic [BPC_OUT-1:0] out_r,
    output logic [BPC_OUT-1:0] out_g,
    output logic [BPC_OUT-1:0] out_b
);

    generate
        if (BPC_IN < BPC_MIN || BPC_IN > BPC_MAX || BPC_OUT < BPC_MIN || BPC_OUT > BPC_MAX ||
            MODE > MODE_DITHER) begin : g_param_check
            $error("disp_colour_adapt: illegal BPC_IN/BPC_OUT/MODE combination");
        end
    endgenerate

    logic       xp_q;
    logic       yp_q;
    logic [1:0] fc_q;
    logic       de_prev_q;
    logic [1:0] bidx;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            xp_q      <= 1'b0;
            yp_q      <= 1'b0;
            fc_q      <= 2'd0;
            de_prev_q <= 1'b0;
        end else begin
            de_prev_q <= disp_de;
            xp_q      <= disp_de ? ~xp_q : 1'b0;
            // Frame start clears the row phase even if a line ends in the same cycle
            if (disp_frame) begin
                yp_q <= 1'b0;
            end else if (de_prev_q && !disp_de) begin
                yp_q <= ~yp_q;
            end
            if (disp_frame) begin
                fc_q <= fc_q + 2'd1;
            end
        end
    end

    assign bidx = bayer_index(yp_q, xp_q, fc_q);

    disp_timing_t tim_q1, tim_q2;

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            tim_q1 <= '0;
            tim_q2 <= '0;
        end else begin
            tim_q1 <= '{hsync: disp_hsync, vsync: disp_vsync, de: disp_de};
            tim_q2 <= tim_q1;
        end
    end

    assign out_hsync = tim_q2.hsync;
    assign out_vsync = tim_q2.vsync;
    assign out_de    = tim_q2.de;

    colour_chan_conv #(
        .BPC_IN  (BPC_IN),
        .BPC_OUT (BPC_OUT),
        .MODE    (MODE)
    ) u_conv_r (
        .clk_pix   (clk_pix),
        .rst_pix   (rst_pix),
        .de        (disp_de),
        .bayer_idx (bidx),
        .pix_in    (disp_r),
        .pix_out   (out_r)
    );

    colour_chan_conv #(
        .BPC_IN  (BPC_IN),
        .BPC_OUT (BPC_OUT),
        .MODE    (MODE)
    ) u_conv_g (
        .clk_pix   (clk_pix),
        .rst_pix   (rst_pix),
        .de        (disp_de),
        .bayer_idx (bidx),
        .pix_in    (disp_g),
        .pix_out   (out_g)
    );

    colour_chan_conv #(
        .BPC_IN  (BPC_IN),
        .BPC_OUT (BPC_OUT),
        .MODE    (MODE)
    ) u_conv_b (
        .clk_pix   (clk_pix),
        .rst_pix   (rst_pix),
        .de        (disp_de),
        .bayer_idx (bidx),
        .pix_in    (disp_b),
        .pix_out   (out_b)
    );

endmodule

// File: tb/tb_disp_colour_adapt.sv
// Directed bench: 5->8 replicate and zero-pad instances plus an 8->5 dither instance.
module tb_disp_colour_adapt;

    logic       clk_pix = 1'b0;
    logic       rst_pix;
    logic       disp_hsync, disp_vsync, disp_de, disp_frame;
    logic [4:0] r5, g5, b5;
    logic [7:0] r8, g8, b8;

    logic       repl_hs, repl_vs, repl_de;
    logic [7:0] repl_r, repl_g, repl_b;
    logic       zero_hs, zero_vs, zero_de;
    logic [7:0] zero_r, zero_g, zero_b;
    logic       dith_hs, dith_vs, dith_de;
    logic [4:0] dith_r, dith_g, dith_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [15:0] pend_exp;
    bit          pend_chk;
    string       pend_tag;

    always #5 clk_pix = ~clk_pix;

    disp_colour_adapt #(.BPC_IN(5), .BPC_OUT(8), .MODE(0)) u_repl (
        .clk_pix(clk_pix), .rst_pix(rst_pix),
        .disp_hsync(disp_hsync), .disp_vsync(disp_vsync), .disp_de(disp_de),
        .disp_frame(disp_frame), .disp_r(r5), .disp_g(g5), .disp_b(b5),
        .out_hsync(repl_hs), .out_vsync(repl_vs), .out_de(repl_de),
        .out_r(repl_r), .out_g(repl_g), .out_b(repl_b)
    );

    disp_colour_adapt #(.BPC_IN(5), .BPC_OUT(8), .MODE(1)) u_zero (
        .clk_pix(clk_pix), .rst_pix(rst_pix),
        .disp_hsync(disp_hsync), .disp_vsync(disp_vsync), .disp_de(disp_de),
        .disp_frame(disp_frame), .disp_r(r5), .disp_g(g5), .disp_b(b5),
        .out_hsync(zero_hs), .out_vsync(zero_vs), .out_de(zero_de),
        .out_r(zero_r), .out_g(zero_g), .out_b(zero_b)
    );

    disp_colour_adapt #(.BPC_IN(8), .BPC_OUT(5), .MODE(2)) u_dith (
        .clk_pix(clk_pix), .rst_pix(rst_pix),
        .disp_hsync(disp_hsync), .disp_vsync(disp_vsync), .disp_de(disp_de),
        .disp_frame(disp_frame), .disp_r(r8), .disp_g(g8), .disp_b(b8),
        .out_hsync(dith_hs), .out_vsync(dith_vs), .out_de(dith_de),
        .out_r(dith_r), .out_g(dith_g), .out_b(dith_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    // Drive one dither pixel; the output for it is checked at the end of the following step.
    task automatic step(input logic de_v, input logic fr_v, input logic [7:0] v,
                        input bit chk, input logic [4:0] e, input string tag);
        disp_de    = de_v;
        disp_frame = fr_v;
        r8 = v;
        g8 = v;
        b8 = v;
        tick();
        if (pend_chk) check_eq(pend_tag, 32'({dith_de, dith_r, dith_g, dith_b}), 32'(pend_exp));
        pend_chk = chk;
        pend_exp = {de_v, e, e, e};
        pend_tag = tag;
    endtask

    initial begin
        pend_chk   = 1'b0;
        pend_exp   = '0;
        pend_tag   = "";
        rst_pix    = 1'b1;
        disp_hsync = 1'b1;
        disp_vsync = 1'b0;
        disp_de    = 1'b1;
        disp_frame = 1'b0;
        r5 = 5'h1F; g5 = 5'h1F; b5 = 5'h1F;
        r8 = 8'hFF; g8 = 8'hFF; b8 = 8'hFF;
        tick();
        tick();
        check_eq("rst_repl_rgb", 32'({repl_r, repl_g, repl_b}), 32'h0);
        check_eq("rst_dith", 32'({dith_de, dith_r, dith_g, dith_b}), 32'h0);
        check_eq("rst_timing", 32'({repl_hs, repl_vs, repl_de}), 32'h0);

        disp_hsync = 1'b0;
        disp_de    = 1'b0;
        r5 = 5'h0; g5 = 5'h0; b5 = 5'h0;
        r8 = 8'h0; g8 = 8'h0; b8 = 8'h0;
        rst_pix = 1'b0;
        tick();
        tick();

        // Expansion 5->8, replicate and zero-pad
        r5 = 5'h1F; g5 = 5'h10; b5 = 5'h01;
        tick();
        check_eq("lat1_repl", 32'({repl_r, repl_g, repl_b}), 32'h0);
        tick();
        check_eq("exp_repl_a", 32'({repl_r, repl_g, repl_b}), 32'hFF8408);
        check_eq("exp_zero_a", 32'({zero_r, zero_g, zero_b}), 32'hF88008);
        r5 = 5'h10; g5 = 5'h01; b5 = 5'h1F;
        tick();
        check_eq("hold_repl_a", 32'({repl_r, repl_g, repl_b}), 32'hFF8408);
        tick();
        check_eq("exp_repl_b", 32'({repl_r, repl_g, repl_b}), 32'h8408FF);
        check_eq("exp_zero_b", 32'({zero_r, zero_g, zero_b}), 32'h8008F8);
        r5 = 5'h0; g5 = 5'h0; b5 = 5'h0;

        // Dither 8->5, frame 0 (fc=0), value 4
        step(1'b1, 1'b0, 8'h04, 1'b1, 5'd0, "f0_p00");
        step(1'b1, 1'b0, 8'h04, 1'b1, 5'd1, "f0_p01");
        step(1'b0, 1'b0, 8'h04, 1'b1, 5'd0, "f0_gap");
        step(1'b1, 1'b0, 8'h04, 1'b1, 5'd1, "f0_p10");
        step(1'b1, 1'b0, 8'h04, 1'b1, 5'd0, "f0_p11");
        // Frame pulse together with the line's falling DE: row phase must restart at 0
        step(1'b0, 1'b1, 8'h06, 1'b1, 5'd0, "f1_frame");
        step(1'b1, 1'b0, 8'h06, 1'b1, 5'd1, "f1_p00");
        step(1'b1, 1'b0, 8'h06, 1'b1, 5'd1, "f1_p01");
        step(1'b0, 1'b0, 8'h06, 1'b1, 5'd0, "f1_gap");
        step(1'b1, 1'b0, 8'h06, 1'b1, 5'd0, "f1_p10");
        step(1'b1, 1'b0, 8'h06, 1'b1, 5'd1, "f1_p11");
        step(1'b0, 1'b1, 8'hFF, 1'b1, 5'h1F, "sat_frame");
        for (int f = 0; f < 2; f++) begin
            step(1'b1, 1'b0, 8'hFF, 1'b1, 5'h1F, "sat_p00");
            step(1'b1, 1'b0, 8'hFF, 1'b1, 5'h1F, "sat_p01");
            step(1'b0, 1'b0, 8'hFF, 1'b1, 5'h1F, "sat_gap");
            step(1'b1, 1'b0, 8'hFF, 1'b1, 5'h1F, "sat_p10");
            step(1'b1, 1'b0, 8'hFF, 1'b1, 5'h1F, "sat_p11");
            step(1'b0, 1'b1, 8'hFF, 1'b1, 5'h1F, "sat_frame");
        end
        step(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, "flush");
        disp_frame = 1'b0;

        // Single-cycle timing pulses
        disp_hsync = 1'b1;
        disp_de    = 1'b1;
        tick();
        check_eq("pulse_lat1", 32'({repl_hs, repl_vs, repl_de}), 32'h0);
        disp_hsync = 1'b0;
        disp_de    = 1'b0;
        disp_vsync = 1'b1;
        tick();
        check_eq("pulse_hs_de", 32'({repl_hs, repl_vs, repl_de, dith_hs, dith_vs, dith_de}),
                 32'h2D);
        disp_vsync = 1'b0;
        tick();
        check_eq("pulse_vs", 32'({repl_hs, repl_vs, repl_de}), 32'h2);
        tick();
        check_eq("pulse_end", 32'({repl_hs, repl_vs, repl_de}), 32'h0);

        // Mid-line asynchronous reset
        disp_de = 1'b1;
        r5 = 5'h1F; g5 = 5'h1F; b5 = 5'h1F;
        r8 = 8'hFF; g8 = 8'hFF; b8 = 8'hFF;
        tick();
        tick();
        check_eq("ml_repl", 32'({repl_r, repl_g, repl_b}), 32'hFFFFFF);
        check_eq("ml_dith", 32'({dith_de, dith_r, dith_g, dith_b}), 32'hFFFF);
        #2;
        rst_pix = 1'b1;
        #1;
        check_eq("async_rst_repl", 32'({repl_r, repl_g, repl_b, repl_de}), 32'h0);
        check_eq("async_rst_dith", 32'({dith_de, dith_r, dith_g, dith_b}), 32'h0);
        disp_de = 1'b0;
        r5 = 5'h0; g5 = 5'h0; b5 = 5'h0;
        r8 = 8'h0; g8 = 8'h0; b8 = 8'h0;
        tick();
        tick();
        rst_pix  = 1'b0;
        pend_chk = 1'b0;

        // Pattern restarts at fc=0, xp=0, yp=0
        step(1'b1, 1'b0, 8'h04, 1'b1, 5'd0, "rr_p00");
        step(1'b1, 1'b0, 8'h04, 1'b1, 5'd1, "rr_p01");
        step(1'b0, 1'b0, 8'h04, 1'b1, 5'd0, "rr_gap");
        step(1'b1, 1'b0, 8'h04, 1'b1, 5'd1, "rr_p10");
        step(1'b1, 1'b0, 8'h04, 1'b1, 5'd0, "rr_p11");
        step(1'b0, 1'b0, 8'h00, 1'b0, 5'd0, "flush");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
